// File: rtl/fetch_queue.sv
// Instruction-fetch front end: pipelined word fetches over a req/gnt/rvalid bus,
// buffered with their PCs in a DEPTH-entry FIFO, flushed on redirect.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
  input  logic                       iCLK,
  input  logic                       iRSTn,
  output logic                       oIReq,
  output logic [XLEN-1:0]            oIAddress,
  input  logic                       iIGnt,
  input  logic                       iIRvalid,
  input  logic [XLEN-1:0]            iIRdata,
  input  logic                       iRedirect,
  input  logic [XLEN-1:0]            iRedirectPC,
  output logic                       oMisalign,
  output logic                       oValid,
  output logic [XLEN-1:0]            oInstr,
  output logic [XLEN-1:0]            oInstrPC,
  input  logic                       iReady,
  output logic [$clog2(DEPTH+1)-1:0] oCount
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetchPC;
  logic [XLEN-1:0] issuePC;
  logic            pend;
  logic            drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [XLEN-1:0] instrMem [DEPTH];
  logic [XLEN-1:0] pcMem    [DEPTH];

  logic spaceOk;
  logic grant;
  logic resp;
  logic push;
  logic pop;

  // Reserve a slot for the outstanding response before asking for another word.
  assign spaceOk = ((CW+1)'(count) + (CW+1)'(pend)) < (CW+1)'(DEPTH);
  assign oIReq   = iRSTn & ~iRedirect & (~pend | iIRvalid) & spaceOk;
  assign grant   = oIReq & iIGnt;
  assign resp    = iIRvalid & pend;
  assign push    = resp & ~drop & ~iRedirect;
  assign pop     = (count != '0) & iReady & ~iRedirect;

  assign oIAddress = fetchPC;
  assign oValid    = (count != '0);
  assign oInstr    = instrMem[rdPtr];
  assign oInstrPC  = pcMem[rdPtr];
  assign oCount    = count;

  // Fetch control, pointers and occupancy; a redirect overrides everything else.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      fetchPC   <= RESET_PC;
      issuePC   <= RESET_PC;
      pend      <= 1'b0;
      drop      <= 1'b0;
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      oMisalign <= 1'b0;
    end else if (iRedirect) begin
      fetchPC   <= {iRedirectPC[XLEN-1:2], 2'b00};
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      pend      <= pend & ~iIRvalid;
      drop      <= pend & ~iIRvalid;
      oMisalign <= (iRedirectPC[1:0] != 2'b00);
    end else begin
      oMisalign <= 1'b0;
      if (grant) begin
        fetchPC <= fetchPC + XLEN'(4);
        issuePC <= fetchPC;
      end
      if (grant) begin
        pend <= 1'b1;
      end else if (resp) begin
        pend <= 1'b0;
      end
      if (resp) begin
        drop <= 1'b0;
      end
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage, cleared on reset so the head never shows stale data.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instrMem[i] <= '0;
        pcMem[i]    <= '0;
      end
    end else if (push) begin
      instrMem[wrPtr] <= iIRdata;
      pcMem[wrPtr]    <= issuePC;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, wait states,
// redirect discard, misalignment, PC wrap and asynchronous reset.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] XORK   = 32'hA5A5_0000;

  logic        iCLK;
  logic        iRSTn;
  logic        oIReq;
  logic [31:0] oIAddress;
  logic        iIGnt;
  logic        iIRvalid;
  logic [31:0] iIRdata;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oMisalign;
  logic        oValid;
  logic [31:0] oInstr;
  logic [31:0] oInstrPC;
  logic        iReady;
  logic [2:0]  oCount;

  int nTests = 0;
  int nFail  = 0;

  int          respLat = 1;
  bit          memBusy = 0;
  int          memCnt  = 0;
  logic [31:0] memAddr = '0;
  int          nGrants = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .oIReq(oIReq), .oIAddress(oIAddress),
    .iIGnt(iIGnt), .iIRvalid(iIRvalid), .iIRdata(iIRdata),
    .iRedirect(iRedirect), .iRedirectPC(iRedirectPC), .oMisalign(oMisalign),
    .oValid(oValid), .oInstr(oInstr), .oInstrPC(oInstrPC),
    .iReady(iReady), .oCount(oCount)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Memory model: one outstanding request, response respLat cycles after grant.
  always @(posedge iCLK) begin
    if (!iRSTn) begin
      memBusy = 0;
    end else if (oIReq && iIGnt) begin
      memBusy = 1;
      memCnt  = respLat;
      memAddr = oIAddress;
      nGrants++;
    end
    #1;
    if (memBusy && memCnt == 1) begin
      iIRvalid = 1'b1;
      iIRdata  = memAddr ^ XORK;
      memBusy  = 0;
    end else begin
      iIRvalid = 1'b0;
      if (memBusy) memCnt--;
    end
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRedirect = 1'b0;
    iRSTn     = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
  endtask

  task automatic test_reset();
    iRSTn = 1'b0; iIGnt = 1'b1; iReady = 1'b1; iRedirect = 1'b0;
    iRedirectPC = '0; iIRvalid = 1'b0; iIRdata = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL reset_req got %b exp 0", oIReq); end
    nTests++; if (oValid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b exp 0", oValid); end
    nTests++; if (oIAddress !== RST_PC) begin nFail++; $display("FAIL reset_addr got %h exp %h", oIAddress, RST_PC); end
    nTests++; if (oCount !== 3'd0) begin nFail++; $display("FAIL reset_count got %0d exp 0", oCount); end
    nTests++; if (oMisalign !== 1'b0) begin nFail++; $display("FAIL reset_misalign got %b exp 0", oMisalign); end
  endtask

  task automatic test_stream();
    logic [31:0] expA, expP;
    iIGnt = 1'b1; iReady = 1'b1; respLat = 1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) cyc();
      @(negedge iCLK);
      expA = RST_PC + 32'(4 * (k - 1));
      nTests++; if (oIAddress !== expA) begin nFail++; $display("FAIL stream_addr c%0d got %h exp %h", k, oIAddress, expA); end
      nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL stream_req c%0d got %b exp 1", k, oIReq); end
      if (k < 3) begin
        nTests++; if (oValid !== 1'b0) begin nFail++; $display("FAIL stream_valid c%0d got %b exp 0", k, oValid); end
      end else begin
        expP = RST_PC + 32'(4 * (k - 3));
        nTests++; if (oValid !== 1'b1) begin nFail++; $display("FAIL stream_valid c%0d got %b exp 1", k, oValid); end
        nTests++; if (oInstrPC !== expP) begin nFail++; $display("FAIL stream_pc c%0d got %h exp %h", k, oInstrPC, expP); end
        nTests++; if (oInstr !== (expP ^ XORK)) begin nFail++; $display("FAIL stream_instr c%0d got %h exp %h", k, oInstr, expP ^ XORK); end
        nTests++; if (oCount !== 3'd1) begin nFail++; $display("FAIL stream_count c%0d got %0d exp 1", k, oCount); end
      end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    iIGnt = 1'b1; iReady = 1'b0; respLat = 1;
    do_reset();
    g0 = nGrants;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) cyc();
      @(negedge iCLK);
      if (k >= 5) begin
        nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL bp_req_full c%0d got %b exp 0", k, oIReq); end
      end
    end
    nTests++; if (nGrants - g0 !== 4) begin nFail++; $display("FAIL bp_grants got %0d exp 4", nGrants - g0); end
    nTests++; if (oCount !== 3'd4) begin nFail++; $display("FAIL bp_count got %0d exp 4", oCount); end
    nTests++; if (oInstrPC !== RST_PC) begin nFail++; $display("FAIL bp_head got %h exp %h", oInstrPC, RST_PC); end
    nTests++; if (oIAddress !== 32'h0040_0010) begin nFail++; $display("FAIL bp_addr got %h exp 00400010", oIAddress); end
    cyc(); iReady = 1'b1;
    @(negedge iCLK);
    nTests++; if (oInstrPC !== RST_PC) begin nFail++; $display("FAIL bp_head_pop got %h exp %h", oInstrPC, RST_PC); end
    cyc(); iReady = 1'b0;
    @(negedge iCLK);
    nTests++; if (oCount !== 3'd3) begin nFail++; $display("FAIL bp_count_pop got %0d exp 3", oCount); end
    nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL bp_req_resume got %b exp 1", oIReq); end
    nTests++; if (oInstrPC !== 32'h0040_0004) begin nFail++; $display("FAIL bp_head_next got %h exp 00400004", oInstrPC); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL bp_req_refull got %b exp 0", oIReq); end
    nTests++; if (nGrants - g0 !== 5) begin nFail++; $display("FAIL bp_grants2 got %0d exp 5", nGrants - g0); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oCount !== 3'd4) begin nFail++; $display("FAIL bp_count_refull got %0d exp 4", oCount); end
  endtask

  task automatic test_wait_states();
    int g0;
    iIGnt = 1'b0; iReady = 1'b0; respLat = 5;
    do_reset();
    g0 = nGrants;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) cyc();
      @(negedge iCLK);
      nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL ws_req c%0d got %b exp 1", k, oIReq); end
      nTests++; if (oIAddress !== RST_PC) begin nFail++; $display("FAIL ws_addr_hold c%0d got %h exp %h", k, oIAddress, RST_PC); end
    end
    cyc(); iIGnt = 1'b1;
    @(negedge iCLK);
    nTests++; if (nGrants !== g0) begin nFail++; $display("FAIL ws_no_grant got %0d exp %0d", nGrants, g0); end
    for (int k = 5; k <= 8; k++) begin
      cyc(); respLat = 1;
      @(negedge iCLK);
      nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL ws_pend_req c%0d got %b exp 0", k, oIReq); end
      nTests++; if (oIAddress !== 32'h0040_0004) begin nFail++; $display("FAIL ws_pend_addr c%0d got %h exp 00400004", k, oIAddress); end
    end
    cyc();
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL ws_resp_req got %b exp 1", oIReq); end
    nTests++; if (nGrants - g0 !== 1) begin nFail++; $display("FAIL ws_grants got %0d exp 1", nGrants - g0); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oValid !== 1'b1) begin nFail++; $display("FAIL ws_valid got %b exp 1", oValid); end
    nTests++; if (oInstrPC !== RST_PC) begin nFail++; $display("FAIL ws_pc got %h exp %h", oInstrPC, RST_PC); end
    nTests++; if (oCount !== 3'd1) begin nFail++; $display("FAIL ws_count got %0d exp 1", oCount); end
  endtask

  task automatic test_redirect_discard();
    iIGnt = 1'b1; iReady = 1'b0; respLat = 3;
    do_reset();
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL rd_req1 got %b exp 1", oIReq); end
    cyc(); iRedirect = 1'b1; iRedirectPC = 32'h0040_0100;
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL rd_req_redirect got %b exp 0", oIReq); end
    cyc(); iRedirect = 1'b0; respLat = 1;
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL rd_req_pend got %b exp 0", oIReq); end
    nTests++; if (oIAddress !== 32'h0040_0100) begin nFail++; $display("FAIL rd_addr got %h exp 00400100", oIAddress); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL rd_req_stale got %b exp 1", oIReq); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oCount !== 3'd0) begin nFail++; $display("FAIL rd_discard_count got %0d exp 0", oCount); end
    nTests++; if (oValid !== 1'b0) begin nFail++; $display("FAIL rd_discard_valid got %b exp 0", oValid); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oValid !== 1'b1) begin nFail++; $display("FAIL rd_valid got %b exp 1", oValid); end
    nTests++; if (oInstrPC !== 32'h0040_0100) begin nFail++; $display("FAIL rd_pc got %h exp 00400100", oInstrPC); end
    nTests++; if (oInstr !== 32'hA5E5_0100) begin nFail++; $display("FAIL rd_instr got %h exp a5e50100", oInstr); end
    nTests++; if (oCount !== 3'd1) begin nFail++; $display("FAIL rd_count got %0d exp 1", oCount); end
  endtask

  task automatic test_misalign();
    iIGnt = 1'b1; iReady = 1'b0; respLat = 1;
    do_reset();
    iRedirect = 1'b1; iRedirectPC = 32'h0040_0102;
    @(negedge iCLK);
    nTests++; if (oMisalign !== 1'b0) begin nFail++; $display("FAIL mis_early got %b exp 0", oMisalign); end
    cyc(); iRedirect = 1'b0;
    @(negedge iCLK);
    nTests++; if (oMisalign !== 1'b1) begin nFail++; $display("FAIL mis_pulse got %b exp 1", oMisalign); end
    nTests++; if (oIAddress !== 32'h0040_0100) begin nFail++; $display("FAIL mis_addr got %h exp 00400100", oIAddress); end
    nTests++; if (oIReq !== 1'b1) begin nFail++; $display("FAIL mis_req got %b exp 1", oIReq); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oMisalign !== 1'b0) begin nFail++; $display("FAIL mis_one_cycle got %b exp 0", oMisalign); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oInstrPC !== 32'h0040_0100) begin nFail++; $display("FAIL mis_pc got %h exp 00400100", oInstrPC); end
    // back-to-back redirects: the second target must win
    cyc(); iRedirect = 1'b1; iRedirectPC = 32'h0040_0200;
    cyc(); iRedirectPC = 32'h0040_0300;
    cyc(); iRedirect = 1'b0;
    @(negedge iCLK);
    nTests++; if (oIAddress !== 32'h0040_0300) begin nFail++; $display("FAIL b2b_addr got %h exp 00400300", oIAddress); end
    nTests++; if (oMisalign !== 1'b0) begin nFail++; $display("FAIL b2b_misalign got %b exp 0", oMisalign); end
    nTests++; if (oCount !== 3'd0) begin nFail++; $display("FAIL b2b_count got %0d exp 0", oCount); end
    cyc(); cyc();
    @(negedge iCLK);
    nTests++; if (oInstrPC !== 32'h0040_0300) begin nFail++; $display("FAIL b2b_pc got %h exp 00400300", oInstrPC); end
  endtask

  task automatic test_wrap_and_async_reset();
    iIGnt = 1'b1; iReady = 1'b0; respLat = 1;
    do_reset();
    iRedirect = 1'b1; iRedirectPC = 32'hFFFF_FFF8;
    cyc(); iRedirect = 1'b0;
    @(negedge iCLK);
    nTests++; if (oIAddress !== 32'hFFFF_FFF8) begin nFail++; $display("FAIL wrap_addr0 got %h exp fffffff8", oIAddress); end
    cyc(); cyc();
    @(negedge iCLK);
    nTests++; if (oIAddress !== 32'h0000_0000) begin nFail++; $display("FAIL wrap_addr2 got %h exp 00000000", oIAddress); end
    cyc();
    cyc(); iReady = 1'b1;
    @(negedge iCLK);
    nTests++; if (oCount !== 3'd3) begin nFail++; $display("FAIL wrap_count got %0d exp 3", oCount); end
    nTests++; if (oInstrPC !== 32'hFFFF_FFF8) begin nFail++; $display("FAIL wrap_pc0 got %h exp fffffff8", oInstrPC); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oInstrPC !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL wrap_pc1 got %h exp fffffffc", oInstrPC); end
    cyc();
    @(negedge iCLK);
    nTests++; if (oInstrPC !== 32'h0000_0000) begin nFail++; $display("FAIL wrap_pc2 got %h exp 00000000", oInstrPC); end
    nTests++; if (oInstr !== 32'hA5A5_0000) begin nFail++; $display("FAIL wrap_instr2 got %h exp a5a50000", oInstr); end
    // reset between clock edges, while responses are streaming
    #2; iRSTn = 1'b0;
    #1;
    nTests++; if (oIReq !== 1'b0) begin nFail++; $display("FAIL areset_req got %b exp 0", oIReq); end
    nTests++; if (oValid !== 1'b0) begin nFail++; $display("FAIL areset_valid got %b exp 0", oValid); end
    nTests++; if (oIAddress !== RST_PC) begin nFail++; $display("FAIL areset_addr got %h exp %h", oIAddress, RST_PC); end
    nTests++; if (oCount !== 3'd0) begin nFail++; $display("FAIL areset_count got %0d exp 0", oCount); end
    nTests++; if (oMisalign !== 1'b0) begin nFail++; $display("FAIL areset_misalign got %b exp 0", oMisalign); end
    cyc(); iRSTn = 1'b1;
    @(negedge iCLK);
    nTests++; if (oIAddress !== RST_PC) begin nFail++; $display("FAIL areset_restart got %h exp %h", oIAddress, RST_PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_discard();
    test_misalign();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
